// File: rtl/alu_wb_master_pkg.sv
// Shared constants for the ALU Wishbone initiator: opcode encodings and FSM state codes.
// Combinational constants only, no latency.
// No flow control of its own.
package alu_wb_master_pkg;

  // Bus widths used by the ALU slave interface
  localparam int OP_W  = 9;
  localparam int OPD_W = 18;
  localparam int RES_W = 48;

  // Opcode space: bit 8 clear selects DSP mode, bit 8 set selects a function
  localparam logic [8:0] ALU_MODE_DSP          = 9'h000;
  localparam logic [8:0] ALU_FUNC_SIN          = 9'h100;
  localparam logic [8:0] ALU_FUNC_COS          = 9'h101;
  localparam logic [8:0] ALU_FUNC_INV_1_PLUS_X = 9'h102;

  // Initiator FSM state encodings
  localparam logic [1:0] ALU_WBM_IDLE = 2'd0;
  localparam logic [1:0] ALU_WBM_REQ  = 2'd1;
  localparam logic [1:0] ALU_WBM_WAIT = 2'd2;
  localparam logic [1:0] ALU_WBM_RESP = 2'd3;

endpackage

// File: rtl/alu_wb_master.sv
// Wishbone initiator for the ALU slave: one client command -> one single-shot bus transaction -> one result pulse.
// Latency: accept edge, 1 REQ cycle, WAIT until ack or timeout, 1 RESP cycle with res_valid; ready again the cycle after RESP.
// Backpressure: cmd_ready is high only in IDLE, so commands are held off (never dropped) while a transaction is in flight.
module alu_wb_master
  import alu_wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  // client command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_op,
  input  logic [17:0]       cmd_al,
  input  logic [17:0]       cmd_bl,
  input  logic [17:0]       cmd_ar,
  input  logic [17:0]       cmd_br,
  input  logic [47:0]       cmd_cl,
  input  logic [47:0]       cmd_cr,
  // client result channel
  output logic              res_valid,
  output logic              res_err,
  output logic [47:0]       res_pl,
  output logic [47:0]       res_pr,
  output logic [TO_W-1:0]   stall_cnt,
  // Wishbone side towards the ALU slave
  output logic              alu_cycle,
  output logic              alu_strobe,
  input  logic              alu_ack,
  input  logic              alu_stall,
  input  logic [47:0]       alu_pl,
  input  logic [47:0]       alu_pr,
  output logic [8:0]        alu_op,
  output logic [17:0]       alu_al,
  output logic [17:0]       alu_bl,
  output logic [17:0]       alu_ar,
  output logic [17:0]       alu_br,
  output logic [47:0]       alu_cl,
  output logic [47:0]       alu_cr
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  logic [1:0]       state_q, state_d;
  logic [8:0]       op_q, op_d;
  logic [17:0]      al_q, al_d;
  logic [17:0]      bl_q, bl_d;
  logic [17:0]      ar_q, ar_d;
  logic [17:0]      br_q, br_d;
  logic [47:0]      cl_q, cl_d;
  logic [47:0]      cr_q, cr_d;
  logic [47:0]      pl_q, pl_d;
  logic [47:0]      pr_q, pr_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]  stall_q, stall_d;

  logic             in_txn;
  logic             in_resp;
  logic [TO_W-1:0]  to_inc;
  logic [TO_W-1:0]  stall_inc;

  assign in_txn  = (state_q == ALU_WBM_REQ) || (state_q == ALU_WBM_WAIT);
  assign in_resp = (state_q == ALU_WBM_RESP);

  // Timeout counter advance; it never wraps because WAIT exits at TO_LIMIT.
  assign to_inc    = to_cnt_q + TO_ONE;
  // Stall counter saturates at all-ones instead of wrapping.
  assign stall_inc = (&stall_q) ? stall_q : (stall_q + TO_ONE);

  // Client-facing outputs: all Moore, decoded from the registered state.
  assign cmd_ready = (state_q == ALU_WBM_IDLE);
  assign res_valid = in_resp;
  assign res_err   = in_resp & err_q;
  assign res_pl    = pl_q;
  assign res_pr    = pr_q;
  assign stall_cnt = stall_q;

  // Bus-facing outputs. Strobe is a one-cycle start pulse for the slave and is
  // never stretched by alu_stall. Operands are forced to zero whenever cycle is
  // low because the slave passes them through combinationally while cycle=1.
  assign alu_cycle  = in_txn;
  assign alu_strobe = (state_q == ALU_WBM_REQ);
  assign alu_op     = in_txn ? op_q : '0;
  assign alu_al     = in_txn ? al_q : '0;
  assign alu_bl     = in_txn ? bl_q : '0;
  assign alu_ar     = in_txn ? ar_q : '0;
  assign alu_br     = in_txn ? br_q : '0;
  assign alu_cl     = in_txn ? cl_q : '0;
  assign alu_cr     = in_txn ? cr_q : '0;

  // Next-state logic for the FSM, operand capture, result latch and counters.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    al_d     = al_q;
    bl_d     = bl_q;
    ar_d     = ar_q;
    br_d     = br_q;
    cl_d     = cl_q;
    cr_d     = cr_q;
    pl_d     = pl_q;
    pr_d     = pr_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    stall_d  = stall_q;

    case (state_q)
      ALU_WBM_IDLE: begin
        // alu_ack is ignored here: cycle is low, so any ack is spurious.
        if (cmd_valid) begin
          op_d     = cmd_op;
          al_d     = cmd_al;
          bl_d     = cmd_bl;
          ar_d     = cmd_ar;
          br_d     = cmd_br;
          cl_d     = cmd_cl;
          cr_d     = cmd_cr;
          to_cnt_d = '0;
          stall_d  = '0;
          err_d    = 1'b0;
          state_d  = ALU_WBM_REQ;
        end
      end

      ALU_WBM_REQ: begin
        if (alu_stall) begin
          stall_d = stall_inc;
        end
        if (alu_ack) begin
          pl_d    = alu_pl;
          pr_d    = alu_pr;
          err_d   = 1'b0;
          state_d = ALU_WBM_RESP;
        end else begin
          state_d = ALU_WBM_WAIT;
        end
      end

      ALU_WBM_WAIT: begin
        if (alu_stall) begin
          stall_d = stall_inc;
        end
        to_cnt_d = to_inc;
        // A real ack wins over a timeout expiring in the same cycle.
        if (alu_ack) begin
          pl_d    = alu_pl;
          pr_d    = alu_pr;
          err_d   = 1'b0;
          state_d = ALU_WBM_RESP;
        end else if (to_inc == TO_LIMIT) begin
          pl_d    = '0;
          pr_d    = '0;
          err_d   = 1'b1;
          state_d = ALU_WBM_RESP;
        end
      end

      ALU_WBM_RESP: begin
        // Single result cycle; also guarantees cycle is low between transactions.
        state_d = ALU_WBM_IDLE;
      end

      default: begin
        state_d = ALU_WBM_IDLE;
      end
    endcase
  end

  // Control state: FSM, error flag and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ALU_WBM_IDLE;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
      stall_q  <= stall_d;
    end
  end

  // Datapath registers: captured operands and latched results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      al_q <= '0;
      bl_q <= '0;
      ar_q <= '0;
      br_q <= '0;
      cl_q <= '0;
      cr_q <= '0;
      pl_q <= '0;
      pr_q <= '0;
    end else begin
      op_q <= op_d;
      al_q <= al_d;
      bl_q <= bl_d;
      ar_q <= ar_d;
      br_q <= br_d;
      cl_q <= cl_d;
      cr_q <= cr_d;
      pl_q <= pl_d;
      pr_q <= pr_d;
    end
  end

endmodule
